shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter FAST_SKIP, default 1: 1 = skip stages whose shift-amount bit is 0; 0 = visit all 5 stages.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 a  input  32  operand; captured on start acceptance.
REQ-006 b  input  32  shift amount; only b[4:0] SHALL be used, b[31:5] ignored.
REQ-007 out  output  32  shift result, held stable until the next accepted start.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  one-cycle pulse when out becomes valid.

Function
REQ-010 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 Start is accepted when start=1 in IDLE or DONE; on acceptance the block SHALL latch a into the accumulator, latch b[4:0] as amt, and set stage index to 4.
REQ-012 Each SHIFT cycle SHALL process exactly one stage k (k = 4..0, descending): if amt[k]=1, acc <= acc >> 2^k (logical, zero-fill from MSB); otherwise acc is unchanged.
REQ-013 FAST_SKIP=0: SHIFT SHALL last exactly 5 cycles; acceptance in cycle T gives done=1 in cycle T+6.
REQ-014 FAST_SKIP=1: only stages with amt[k]=1 SHALL be visited; SHIFT lasts popcount(amt) cycles; done in cycle T+1+popcount(amt).
REQ-015 amt=0 with FAST_SKIP=1 SHALL go directly IDLE->DONE; out=a, done in cycle T+1.
REQ-016 After the last stage, the FSM SHALL enter DONE for exactly one cycle, then return to IDLE unless start=1 in that cycle, in which case it SHALL go to SHIFT, or to DONE if FAST_SKIP=1 and amt=0.
REQ-017 start while busy=1 SHALL be ignored, without corrupting acc or amt.
REQ-018 out SHALL equal acc; the value at done SHALL equal a >> b[4:0].
REQ-019 busy and done SHALL never both be 1.

Reset
REQ-020 While reset=1: state=IDLE, out=0, busy=0, done=0, amt=0, stage index=4, independent of clk.
REQ-021 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow for the aborted operation.

Configuration
REQ-022 Macro SHIFT_SEQUENCER_LEFT_EN defined: add input dir (1 bit, latched on acceptance); dir=1 SHALL shift left with zero-fill from LSB, dir=0 SHALL shift right; timing is unchanged.
REQ-023 Macro undefined: no dir port; right shift only.

Structure
REQ-024 Shared package shift_pkg SHALL hold the FSM state typedef, SHIFT_WIDTH=32, and SHIFT_STAGES=5.
REQ-025 One sub-module shift_stage (32-bit input, stage index, enable, optional dir) SHALL implement the per-cycle variable-distance mux row; a single instance SHALL be shared by all stages.

Verification
REQ-026 FAST_SKIP=1, a=0x80000000, b=8 -> busy 1 cycle, done at T+2, out=0x00800000.
REQ-027 FAST_SKIP=0, a=0xFFFFFFFF, b=31 -> busy cycles T+1..T+5, done at T+6, out=0x00000001.
REQ-028 FAST_SKIP=1, a=0x12345678, b=0 -> done at T+1, out=0x12345678, busy never 1.
REQ-029 a=0xF0000000, b=0x25, start re-pulsed with a=0, b=1 while busy -> out=0x07800000, second start ignored.
REQ-030 reset pulsed at T+2 of a b=31 operation -> out=0, busy=0, no done, next start operates normally.
REQ-031 SHIFT_SEQUENCER_LEFT_EN defined, dir=1, a=0x00000001, b=4 -> out=0x00000010 with the same latency as the right shift.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle barrel shift sequencer.
// Includes the stage-selection helpers used when empty shift stages are skipped.
package shift_pkg;

    localparam int SHIFT_WIDTH  = 32;
    localparam int SHIFT_STAGES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Highest stage k <= fromStage with amt[k] set; returns fromStage if none.
    function automatic logic [2:0] highestSetAtOrBelow(input logic [SHIFT_STAGES-1:0] amt,
                                                       input logic [2:0]              fromStage);
        logic [2:0] result;
        result = fromStage;
        for (int k = 0; k < SHIFT_STAGES; k++) begin
            if ((3'(k) <= fromStage) && amt[k]) begin
                result = 3'(k);
            end
        end
        return result;
    endfunction

    function automatic logic [SHIFT_STAGES-1:0] belowMask(input logic [2:0] stage);
        return (SHIFT_STAGES'(1) << stage) - SHIFT_STAGES'(1);
    endfunction

endpackage

// File: rtl/shift_sequencer_stage.sv
// One row of the barrel shifter: shifts by 2^i_stage when enabled, otherwise passes through.
// Macro SHIFT_SEQUENCER_LEFT_EN adds i_dir (1 = left shift).
module shift_stage
    import shift_pkg::*;
(
    input  logic [SHIFT_WIDTH-1:0] i_data,
    input  logic [2:0]             i_stage,
    input  logic                   i_en,
`ifdef SHIFT_SEQUENCER_LEFT_EN
    input  logic                   i_dir,
`endif
    output logic [SHIFT_WIDTH-1:0] o_data
);

    logic [5:0] w_dist;

    assign w_dist = 6'(1) << i_stage;

    always_comb begin
        o_data = i_data;
        if (i_en) begin
`ifdef SHIFT_SEQUENCER_LEFT_EN
            if (i_dir) begin
                o_data = i_data << w_dist;
            end else begin
                o_data = i_data >> w_dist;
            end
`else
            o_data = i_data >> w_dist;
`endif
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: one power-of-two stage per cycle, optionally skipping zero stages.
// Macro SHIFT_SEQUENCER_LEFT_EN adds the dir input for left shifts.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int FAST_SKIP = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SHIFT_WIDTH-1:0] a,
    input  logic [SHIFT_WIDTH-1:0] b,
`ifdef SHIFT_SEQUENCER_LEFT_EN
    input  logic                   dir,
`endif
    output logic [SHIFT_WIDTH-1:0] out,
    output logic                   busy,
    output logic                   done
);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [SHIFT_WIDTH-1:0]  r_acc;
    logic [SHIFT_STAGES-1:0] r_amt;
    logic [2:0]              r_stage;
    logic                    r_dir;

    logic                    w_accept;
    logic [2:0]              w_curStage;
    logic                    w_lastStage;
    logic                    w_stageEn;
    logic [SHIFT_WIDTH-1:0]  w_stageOut;
    logic                    w_unused;

    assign w_unused = ^{b[SHIFT_WIDTH-1:SHIFT_STAGES], r_dir};

    assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_curStage  = (FAST_SKIP != 0) ? highestSetAtOrBelow(r_amt, r_stage) : r_stage;
    assign w_lastStage = (FAST_SKIP != 0) ? ((r_amt & belowMask(w_curStage)) == '0)
                                          : (w_curStage == 3'd0);
    assign w_stageEn   = r_amt[w_curStage];

    shift_stage u_stage (
        .i_data  (r_acc),
        .i_stage (w_curStage),
        .i_en    (w_stageEn),
`ifdef SHIFT_SEQUENCER_LEFT_EN
        .i_dir   (r_dir),
`endif
        .o_data  (w_stageOut)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_nextState = ((FAST_SKIP != 0) && (b[SHIFT_STAGES-1:0] == '0)) ? DONE : SHIFT;
                end else begin
                    w_nextState = IDLE;
                end
            end
            SHIFT: begin
                if (w_lastStage) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_amt   <= '0;
            r_stage <= 3'd4;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_acc   <= a;
                r_amt   <= b[SHIFT_STAGES-1:0];
                r_stage <= 3'd4;
`ifdef SHIFT_SEQUENCER_LEFT_EN
                r_dir   <= dir;
`endif
            end else if (r_state == SHIFT) begin
                r_acc   <= w_stageOut;
                r_stage <= w_lastStage ? 3'd4 : (w_curStage - 3'd1);
            end
        end
    end

    assign out  = r_acc;
    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: runs a FAST_SKIP=1 and a FAST_SKIP=0 instance side by side.
// Left-shift vectors are exercised only when SHIFT_SEQUENCER_LEFT_EN is defined.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
`ifdef SHIFT_SEQUENCER_LEFT_EN
    logic        dir;
`endif
    logic [31:0] outS, outN;
    logic        busyS, busyN, doneS, doneN;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expOut;
        int          pop;
    } vec_t;

    vec_t vecs[8];

    shift_sequencer #(.FAST_SKIP(1)) dutSkip (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SHIFT_SEQUENCER_LEFT_EN
        .dir   (dir),
`endif
        .out   (outS),
        .busy  (busyS),
        .done  (doneS)
    );

    shift_sequencer #(.FAST_SKIP(0)) dutFull (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SHIFT_SEQUENCER_LEFT_EN
        .dir   (dir),
`endif
        .out   (outN),
        .busy  (busyN),
        .done  (doneN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Starts one operation on both instances and watches 12 cycles for latency, busy length and hold.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input bit repulse,
                                 input logic [31:0] expOut, input int expPop);
        int doneAtS, doneAtN, busyCntS, busyCntN, doneCntS, doneCntN;
        logic [31:0] resS, resN;
        bit overlap;
        doneAtS = 0; doneAtN = 0; busyCntS = 0; busyCntN = 0; doneCntS = 0; doneCntN = 0;
        resS = 'x; resN = 'x; overlap = 0;
        @(negedge clk);
        a = opA; b = opB; start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (repulse) begin
                    a = 32'h0; b = 32'h1;
                end else begin
                    start = 1'b0;
                end
            end
            if (n == 2) start = 1'b0;
            if (busyS) busyCntS++;
            if (busyN) busyCntN++;
            if (doneS) begin
                doneCntS++;
                if (doneAtS == 0) begin doneAtS = n; resS = outS; end
            end
            if (doneN) begin
                doneCntN++;
                if (doneAtN == 0) begin doneAtN = n; resN = outN; end
            end
            if ((busyS && doneS) || (busyN && doneN)) overlap = 1;
        end
        checkOutput("skip_out", resS, expOut);
        checkOutput("full_out", resN, expOut);
        checkOutput("skip_latency", 32'(doneAtS), 32'(1 + expPop));
        checkOutput("full_latency", 32'(doneAtN), 32'd6);
        checkOutput("skip_busy_cycles", 32'(busyCntS), 32'(expPop));
        checkOutput("full_busy_cycles", 32'(busyCntN), 32'd5);
        checkOutput("skip_done_pulses", 32'(doneCntS), 32'd1);
        checkOutput("busy_done_overlap", {31'd0, overlap}, 32'd0);
        checkOutput("skip_hold", outS, expOut);
        checkOutput("full_hold", outN, expOut);
    endtask

    initial begin
        int doneCnt;
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef SHIFT_SEQUENCER_LEFT_EN
        dir = 1'b0;
`endif
        vecs[0] = '{32'h80000000, 32'h00000008, 32'h00800000, 1};
        vecs[1] = '{32'hFFFFFFFF, 32'h0000001F, 32'h00000001, 5};
        vecs[2] = '{32'h12345678, 32'h00000000, 32'h12345678, 0};
        vecs[3] = '{32'hDEADBEEF, 32'h00000004, 32'h0DEADBEE, 1};
        vecs[4] = '{32'hA5A5A5A5, 32'hFFFFFFF0, 32'h0000A5A5, 1};
        vecs[5] = '{32'h12345678, 32'h00000013, 32'h00000246, 3};
        vecs[6] = '{32'h80000001, 32'h00000001, 32'h40000000, 1};
        vecs[7] = '{32'h0000FFFF, 32'h0000000A, 32'h0000003F, 2};

        #12;
        checkOutput("reset_skip", {outS[31:2], busyS, doneS}, 32'd0);
        checkOutput("reset_full", {outN[31:2], busyN, doneN}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b0, vecs[i].expOut, vecs[i].pop);
        end

        // Second start while busy must be ignored.
        applyStimulus(32'hF0000000, 32'h00000025, 1'b1, 32'h07800000, 2);

        // Back-to-back: new start accepted in the DONE cycle goes straight to SHIFT.
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("b2b_done1", {30'd0, doneS, doneN}, 32'd3);
        a = 32'h80000000; b = 32'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy", {30'd0, busyS, busyN}, 32'd3);
        repeat (5) @(negedge clk);
        checkOutput("b2b_done2", {30'd0, doneS, doneN}, 32'd3);
        checkOutput("b2b_out_skip", outS, 32'h00000001);
        checkOutput("b2b_out_full", outN, 32'h00000001);

        // Zero shift amount accepted in DONE yields DONE again for the skipping instance.
        repeat (2) @(negedge clk);
        a = 32'h11111111; b = 32'd0; start = 1'b1;
        @(negedge clk);
        checkOutput("zz_done1", {31'd0, doneS}, 32'd1);
        checkOutput("zz_out1", outS, 32'h11111111);
        a = 32'h22222222;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zz_done2", {31'd0, doneS}, 32'd1);
        checkOutput("zz_out2", outS, 32'h22222222);
        @(negedge clk);
        checkOutput("zz_idle", {31'd0, doneS}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("zz_full_done", {31'd0, doneN}, 32'd1);
        checkOutput("zz_full_out", outN, 32'h11111111);

        // Reset in the middle of a shift aborts it without a done pulse.
        repeat (2) @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_skip", outS, 32'd0);
        checkOutput("abort_full", outN, 32'd0);
        checkOutput("abort_flags", {28'd0, busyS, doneS, busyN, doneN}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        doneCnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (doneS || doneN) doneCnt++;
        end
        checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
        applyStimulus(32'h80000000, 32'h00000008, 1'b0, 32'h00800000, 1);

`ifdef SHIFT_SEQUENCER_LEFT_EN
        dir = 1'b1;
        applyStimulus(32'h00000001, 32'h00000004, 1'b0, 32'h00000010, 1);
        applyStimulus(32'h0000FFFF, 32'h00000018, 1'b0, 32'hFF000000, 2);
        dir = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
